// File: rtl/pipe_fifo_buf.sv
// Sink-side elastic buffer: DEPTH-entry FIFO whose upstream ready comes only from registered occupancy.
// Optional same-cycle pass-through when empty: define PIPE_FIFO_BUF_BYPASS_EN.
module pipe_fifo_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AFULL = DEPTH - 1
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_input_valid,
  output logic                       o_input_ready,
  input  logic [WIDTH-1:0]           i_input_data,
  output logic                       o_output_valid,
  input  logic                       i_output_ready,
  output logic [WIDTH-1:0]           o_output_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic full, empty;
  logic push, wr_en, rd_en;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  assign o_input_ready = ~full;
  assign o_count       = count_q;
  assign o_almost_full = (count_q >= CW'(AFULL));

  assign push  = i_input_valid & ~full;
  assign rd_en = ~empty & i_output_ready;

`ifdef PIPE_FIFO_BUF_BYPASS_EN
  // An empty buffer hands the incoming beat straight through when taken.
  assign o_output_valid = ~empty | i_input_valid;
  assign o_output_data  = ~empty ? mem_q[rd_ptr_q]
                        : (i_input_valid ? i_input_data : '0);
  assign wr_en = push & ~(empty & i_output_ready);
`else
  assign o_output_valid = ~empty;
  assign o_output_data  = ~empty ? mem_q[rd_ptr_q] : '0;
  assign wr_en = push;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= i_input_data;
  end

endmodule
